// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: field widths and the queue entry record.
package fetch_pkg;

  localparam int unsigned addressWidth            = 64;
  localparam int unsigned instructionWidth        = 32;
  localparam int unsigned bundleSize              = 128;
  localparam int unsigned PidSize                 = 20;
  localparam int unsigned TidSize                 = 16;
  localparam int unsigned instructionCounterWidth = 64;

  // Instructions per fetch bundle.
  localparam int unsigned BundleSlots = bundleSize / instructionWidth;

  typedef struct packed {
    logic [instructionWidth-1:0]        instruction;
    logic [addressWidth-1:0]            address;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] maj_id;
  } queue_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array backing the fetch queue.
//   clock_i, reset_i : clock, async active-low clear of every entry
//   wr_en_i/wr_idx_i/wr_data_i : one enable/index/entry per write port
//   rd_idx_i/rd_data_o : single combinational read port
module fetch_queue_storage
  import fetch_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter int unsigned NumWrPorts = 4,
  parameter int unsigned IdxW       = $clog2(Depth)
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic         [NumWrPorts-1:0]           wr_en_i,
  input  logic         [NumWrPorts-1:0][IdxW-1:0] wr_idx_i,
  input  queue_entry_t [NumWrPorts-1:0]           wr_data_i,
  input  logic                        [IdxW-1:0]  rd_idx_i,
  output queue_entry_t                            rd_data_o
);

  queue_entry_t mem_q [Depth];
  queue_entry_t mem_d [Depth];

  // Ports never collide in legal use; a higher port would win if they did.
  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NumWrPorts; p++) begin
      if (wr_en_i[p]) begin
        mem_d[wr_idx_i[p]] = wr_data_i[p];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Splits 1-4 instruction bundles into
// per-instruction entries and presents them in order with a valid/ready handshake.
//   clock_i, reset_i (async, active-low), flush_i : control
//   bundle*_i : incoming fetch bundle; fetchStall_o : back-pressure to fetch
//   inst*_o / instReady_i : head entry to the decoder
//   overflow_o : sticky, set when a bundle was dropped for lack of space
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned queueDepth   = 16,
  parameter int unsigned stallReserve = 8
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               bundleEnable_i,
  input  logic [bundleSize-1:0]              bundle_i,
  input  logic [addressWidth-1:0]            bundleAddress_i,
  input  logic [1:0]                         bundleLen_i,
  input  logic [PidSize-1:0]                 bundlePid_i,
  input  logic [TidSize-1:0]                 bundleTid_i,
  input  logic [instructionCounterWidth-1:0] bundleStartMajId_i,
  output logic                               fetchStall_o,
  output logic                               instValid_o,
  input  logic                               instReady_i,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instAddress_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic                               overflow_o
);

  localparam int unsigned PtrW = $clog2(queueDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(queueDepth);
  localparam logic [CntW-1:0] StallC = CntW'(stallReserve);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [CntW-1:0] free;
  logic [CntW-1:0] push_len;
  logic            push_ok;
  logic            pop;

  logic         [BundleSlots-1:0]           wr_en;
  logic         [BundleSlots-1:0][PtrW-1:0] wr_idx;
  queue_entry_t [BundleSlots-1:0]           wr_data;
  queue_entry_t                             head;

  always_comb begin
    free     = DepthC - count_q;
    push_len = CntW'(bundleLen_i) + CntW'(1);
    // Space check uses the pre-pop count.
    push_ok  = bundleEnable_i && (free >= push_len);
    pop      = (count_q != '0) && instReady_i;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_len);
        count_d  = count_q + push_len;
      end else if (bundleEnable_i) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d  = count_d - CntW'(1);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < BundleSlots; p++) begin
      wr_en[p]               = push_ok && !flush_i && (2'(p) <= bundleLen_i);
      wr_idx[p]              = wr_ptr_q + PtrW'(p);
      wr_data[p].instruction = bundle_i[instructionWidth*p +: instructionWidth];
      wr_data[p].address     = bundleAddress_i + addressWidth'(4 * p);
      wr_data[p].pid         = bundlePid_i;
      wr_data[p].tid         = bundleTid_i;
      wr_data[p].maj_id      = bundleStartMajId_i + instructionCounterWidth'(p);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fetch_queue_storage #(
    .Depth      (queueDepth),
    .NumWrPorts (BundleSlots),
    .IdxW       (PtrW)
  ) u_storage (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_ptr_q),
    .rd_data_o (head)
  );

  // Registered-only decode: no path from any input to the stall.
  assign fetchStall_o  = (free < StallC);
  assign instValid_o   = (count_q != '0);
  assign overflow_o    = overflow_q;
  assign instruction_o = head.instruction;
  assign instAddress_o = head.address;
  assign instPid_o     = head.pid;
  assign instTid_o     = head.tid;
  assign instMajId_o   = head.maj_id;

endmodule
